aha_sram_arbiter: RTL and testbench

//  Two-requester round-robin arbiter/sequencer for one single-port 4Kx64 SRAM macro (CEn/WEn/A/D/Q, active-low enables).

---
 rtl/aha_sram_arb_pkg.sv | 10 +
 rtl/aha_rr_arb2.sv | 22 ++
 rtl/aha_sram_arbiter.sv | 121 ++++++++++++
 tb/tb_aha_sram_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aha_sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package aha_sram_arb_pkg;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam int DEF_AW = 12;
  localparam int DEF_DW = 64;

  localparam int P_CPU = 0;
  localparam int P_DMA = 1;
endpackage

// File: rtl/aha_rr_arb2.sv
// 2-way round-robin grant: a lone requester always wins; on a tie the port
// that did not win last time is granted. Nothing is granted unless advance=1.
module aha_rr_arb2
  import aha_sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       advance,
  output logic [1:0] grant
);
  always_comb begin
    grant = '0;
    if (advance) begin
      if (req[P_CPU] && req[P_DMA]) begin
        if (last_grant) grant[P_CPU] = 1'b1;
        else            grant[P_DMA] = 1'b1;
      end else begin
        grant = req;
      end
    end
  end
endmodule

// File: rtl/aha_sram_arbiter.sv
// CPU/DMA round-robin sequencer for one single-port SRAM macro.
// Define AHA_SRAM_ARB_INIT_EN to add the post-reset INIT_VALUE sweep.
module aha_sram_arbiter
  import aha_sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_AW,
  parameter int DATA_WIDTH = DEF_DW,
  parameter     INIT_VALUE = 64'h0,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             CLK,
  input  logic                             RESETn,
  output logic                             init_done,
  input  logic [1:0]                       rq_valid,
  output logic [1:0]                       rq_ready,
  input  logic [1:0]                       rq_write,
  input  logic [1:0][ADDR_WIDTH-1:0]       rq_addr,
  input  logic [1:0][DATA_WIDTH-1:0]       rq_wdata,
  input  logic [1:0][STRB_WIDTH-1:0]       rq_wstrb,
  output logic [1:0]                       rs_valid,
  output logic [DATA_WIDTH-1:0]            rs_rdata,
  output logic                             sram_cen,
  output logic [STRB_WIDTH-1:0]            sram_wen,
  output logic [ADDR_WIDTH-1:0]            sram_a,
  output logic [DATA_WIDTH-1:0]            sram_d,
  input  logic [DATA_WIDTH-1:0]            sram_q
);
  if ($bits(INIT_VALUE) != DATA_WIDTH) begin : g_init_w_chk
    $error("INIT_VALUE width must equal DATA_WIDTH");
  end

  logic                  run;
  logic [1:0]            grant;
  logic                  last_grant;
  logic                  win;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] d_q;

`ifdef AHA_SRAM_ARB_INIT_EN
  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  sweep;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter stops at the top address; the FSM leaves INIT the cycle after.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_INIT) begin
      if (&cnt) state_nxt = ST_RUN;
      else      cnt_nxt   = cnt + 1'b1;
    end
  end

  assign sweep     = RESETn && (state == ST_INIT);
  assign run       = RESETn && (state == ST_RUN);
  assign init_done = (state == ST_RUN);
`else
  assign run       = RESETn;
  assign init_done = 1'b1;
`endif

  aha_rr_arb2 u_arb (
    .req        (rq_valid),
    .last_grant (last_grant),
    .advance    (run),
    .grant      (grant)
  );

  // A grant is always a handshake: grant only goes to a valid port.
  assign rq_ready = grant;
  assign win      = grant[P_DMA];
  assign rs_rdata = sram_q;

  always_comb begin
    sram_cen = 1'b1;
    sram_wen = '1;
    sram_a   = a_q;
    sram_d   = d_q;
`ifdef AHA_SRAM_ARB_INIT_EN
    if (sweep) begin
      sram_cen = 1'b0;
      sram_wen = '0;
      sram_a   = cnt;
      sram_d   = INIT_VALUE;
    end
`endif
    if (|grant) begin
      sram_cen = 1'b0;
      sram_a   = rq_addr[win];
      if (rq_write[win]) begin
        sram_wen = ~rq_wstrb[win];
        sram_d   = rq_wdata[win];
      end
    end
  end

  // a_q/d_q give the macro address/data bus its hold-when-idle behaviour.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      last_grant <= 1'b1;
      rs_valid   <= '0;
      a_q        <= '0;
      d_q        <= '0;
    end else begin
      rs_valid <= grant;
      if (|grant) last_grant <= win;
      a_q <= sram_a;
      d_q <= sram_d;
    end
  end
endmodule

// File: tb/tb_aha_sram_arbiter.sv
// Directed bench for aha_sram_arbiter with a behavioural 4Kx64 macro model.
module tb_aha_sram_arbiter;
  localparam int AW = 12;
  localparam int DW = 64;
  localparam int SW = 8;

  localparam logic [63:0] DX    = 64'h1122334455667788;
  localparam logic [63:0] DF    = 64'hFFFFFFFF_AAAAAAAA;
  localparam logic [63:0] DP    = 64'h11223344_AAAAAAAA;
  localparam logic [63:0] DONES = 64'hFFFFFFFF_FFFFFFFF;
  localparam logic [63:0] DA0   = 64'hA0;
  localparam logic [63:0] DB1   = 64'hB1;
  localparam logic [63:0] DZ    = 64'h0;

  logic                 CLK, RESETn, init_done;
  logic [1:0]           rq_valid, rq_ready, rq_write, rs_valid;
  logic [1:0][AW-1:0]   rq_addr;
  logic [1:0][DW-1:0]   rq_wdata;
  logic [1:0][SW-1:0]   rq_wstrb;
  logic [DW-1:0]        rs_rdata, sram_d, sram_q;
  logic                 sram_cen;
  logic [SW-1:0]        sram_wen;
  logic [AW-1:0]        sram_a;

  int n_cmp = 0;
  int n_err = 0;

  aha_sram_arbiter dut (
    .CLK(CLK), .RESETn(RESETn), .init_done(init_done),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_write(rq_write),
    .rq_addr(rq_addr), .rq_wdata(rq_wdata), .rq_wstrb(rq_wstrb),
    .rs_valid(rs_valid), .rs_rdata(rs_rdata),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Macro model: byte-masked write, registered read data.
  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] q;
  assign sram_q = q;

  function automatic logic [63:0] pat(input int i);
    return 64'hDEADBEEF_00000000 | 64'(i);
  endfunction

  function automatic logic [63:0] exp_init(input int i);
`ifdef AHA_SRAM_ARB_INIT_EN
    return (i >= 0) ? DZ : DZ;
`else
    return pat(i);
`endif
  endfunction

  initial begin
    q = '0;
    for (int i = 0; i < 4096; i++) mem[i] = pat(i);
  end

  always @(posedge CLK) begin
    if (!sram_cen) begin
      for (int b = 0; b < SW; b++)
        if (!sram_wen[b]) mem[sram_a][b*8 +: 8] <= sram_d[b*8 +: 8];
      if (&sram_wen) q <= mem[sram_a];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  v, w;
    logic [11:0] a0, a1;
    logic [63:0] d0, d1;
    logic [7:0]  s0, s1;
    logic [1:0]  rdy;
    logic        cen;
    logic [7:0]  wen;
    logic [11:0] ea;
    logic [63:0] ed;
    logic [1:0]  rs;
    logic        chk_rd;
    logic [63:0] rd;
  } vec_t;

  vec_t tv [14];

  task automatic drive(input vec_t t);
    rq_valid    = t.v;
    rq_write    = t.w;
    rq_addr[0]  = t.a0;
    rq_addr[1]  = t.a1;
    rq_wdata[0] = t.d0;
    rq_wdata[1] = t.d1;
    rq_wstrb[0] = t.s0;
    rq_wstrb[1] = t.s1;
  endtask

  // DMA read of 0xABC; expected to be accepted in the cycle it is driven.
  task automatic read_abc();
    rq_valid   = 2'b10;
    rq_write   = 2'b00;
    rq_addr[1] = 12'hABC;
    #1;
    chk("abc_ready", rq_ready, 2'b10);
    chk("abc_cen", sram_cen, 1'b0);
    chk("abc_a", sram_a, 12'hABC);
    chk("abc_init_done", init_done, 1'b1);
    @(posedge CLK); #1;
    chk("abc_rs", rs_valid, 2'b10);
    chk("abc_rdata", rs_rdata, exp_init(12'hABC));
  endtask

  logic exp_done_rst;
  int   bad;
  logic found;

  initial begin
`ifdef AHA_SRAM_ARB_INIT_EN
    exp_done_rst = 1'b0;
`else
    exp_done_rst = 1'b1;
`endif
    tv[0]  = '{2'b01, 2'b01, 12'h010, 12'h000, DX, DZ, 8'hFF, 8'h00, 2'b01, 1'b0, 8'h00, 12'h010, DX, 2'b01, 1'b0, DZ};
    tv[1]  = '{2'b01, 2'b00, 12'h010, 12'h000, DZ, DZ, 8'h00, 8'h00, 2'b01, 1'b0, 8'hFF, 12'h010, DX, 2'b01, 1'b1, DX};
    tv[2]  = '{2'b01, 2'b01, 12'h010, 12'h000, DF, DZ, 8'h0F, 8'h00, 2'b01, 1'b0, 8'hF0, 12'h010, DF, 2'b01, 1'b0, DZ};
    tv[3]  = '{2'b10, 2'b00, 12'h000, 12'h010, DZ, DZ, 8'h00, 8'h00, 2'b10, 1'b0, 8'hFF, 12'h010, DF, 2'b10, 1'b1, DP};
    tv[4]  = '{2'b00, 2'b00, 12'h000, 12'h000, DZ, DZ, 8'h00, 8'h00, 2'b00, 1'b1, 8'hFF, 12'h010, DF, 2'b00, 1'b0, DZ};
    tv[5]  = '{2'b11, 2'b11, 12'h020, 12'h021, DA0, DB1, 8'hFF, 8'hFF, 2'b01, 1'b0, 8'h00, 12'h020, DA0, 2'b01, 1'b0, DZ};
    tv[6]  = '{2'b11, 2'b10, 12'h021, 12'h021, DZ, DB1, 8'h00, 8'hFF, 2'b10, 1'b0, 8'h00, 12'h021, DB1, 2'b10, 1'b0, DZ};
    tv[7]  = '{2'b11, 2'b00, 12'h021, 12'h020, DZ, DZ, 8'h00, 8'h00, 2'b01, 1'b0, 8'hFF, 12'h021, DB1, 2'b01, 1'b1, DB1};
    tv[8]  = '{2'b11, 2'b01, 12'h022, 12'h020, DONES, DZ, 8'h00, 8'h00, 2'b10, 1'b0, 8'hFF, 12'h020, DB1, 2'b10, 1'b1, DA0};
    tv[9]  = '{2'b11, 2'b01, 12'h022, 12'h022, DONES, DZ, 8'h00, 8'h00, 2'b01, 1'b0, 8'hFF, 12'h022, DONES, 2'b01, 1'b0, DZ};
    tv[10] = '{2'b11, 2'b00, 12'h022, 12'h022, DZ, DZ, 8'h00, 8'h00, 2'b10, 1'b0, 8'hFF, 12'h022, DONES, 2'b10, 1'b1, exp_init(12'h022)};
    tv[11] = '{2'b10, 2'b00, 12'h000, 12'h010, DZ, DZ, 8'h00, 8'h00, 2'b10, 1'b0, 8'hFF, 12'h010, DONES, 2'b10, 1'b1, DP};
    tv[12] = '{2'b11, 2'b00, 12'h020, 12'h021, DZ, DZ, 8'h00, 8'h00, 2'b01, 1'b0, 8'hFF, 12'h020, DONES, 2'b01, 1'b1, DA0};
    tv[13] = '{2'b00, 2'b00, 12'h000, 12'h000, DZ, DZ, 8'h00, 8'h00, 2'b00, 1'b1, 8'hFF, 12'h020, DONES, 2'b00, 1'b0, DZ};

    // Reset with both ports requesting: nothing may be accepted.
    RESETn = 1'b1;
    rq_valid = 2'b11; rq_write = 2'b11;
    rq_addr[0] = 12'h123; rq_addr[1] = 12'h456;
    rq_wdata[0] = DX; rq_wdata[1] = DF;
    rq_wstrb[0] = 8'hFF; rq_wstrb[1] = 8'hFF;
    #2 RESETn = 1'b0;
    #1;
    chk("rst_ready", rq_ready, 2'b00);
    chk("rst_rs", rs_valid, 2'b00);
    chk("rst_cen", sram_cen, 1'b1);
    chk("rst_wen", sram_wen, 8'hFF);
    chk("rst_a", sram_a, 12'h000);
    chk("rst_d", sram_d, DZ);
    chk("rst_init_done", init_done, exp_done_rst);
    repeat (2) @(negedge CLK);

`ifdef AHA_SRAM_ARB_INIT_EN
    RESETn = 1'b1;
    bad = 0;
    for (int k = 0; k < 4096; k++) begin
      #1;
      if (sram_cen !== 1'b0 || sram_wen !== 8'h00 || sram_a !== 12'(k) ||
          sram_d !== DZ || rq_ready !== 2'b00 || init_done !== 1'b0) bad++;
      @(negedge CLK);
    end
    chk("sweep_bad_cycles", 64'(bad), 64'd0);
    rq_valid = 2'b00;
    #1;
    chk("sweep_done", init_done, 1'b1);
    chk("sweep_idle_cen", sram_cen, 1'b1);
    read_abc();
`else
    RESETn = 1'b1;
    read_abc();
`endif

    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d_ready", i), rq_ready, tv[i].rdy);
      chk($sformatf("v%0d_cen", i), sram_cen, tv[i].cen);
      chk($sformatf("v%0d_wen", i), sram_wen, tv[i].wen);
      chk($sformatf("v%0d_a", i), sram_a, tv[i].ea);
      chk($sformatf("v%0d_d", i), sram_d, tv[i].ed);
      @(posedge CLK); #1;
      chk($sformatf("v%0d_rs", i), rs_valid, tv[i].rs);
      if (tv[i].chk_rd) chk($sformatf("v%0d_rdata", i), rs_rdata, tv[i].rd);
    end

    // Reset while a response is pending drops it at once.
    @(negedge CLK);
    rq_valid = 2'b01; rq_write = 2'b00; rq_addr[0] = 12'h010;
    @(posedge CLK); #1;
    chk("mid_rs_pre", rs_valid, 2'b01);
    RESETn = 1'b0;
    #1;
    chk("mid_rs_drop", rs_valid, 2'b00);
    chk("mid_ready", rq_ready, 2'b00);
    chk("mid_cen", sram_cen, 1'b1);
    chk("mid_a", sram_a, 12'h000);
    chk("mid_init_done", init_done, exp_done_rst);
    rq_valid = 2'b00;

`ifdef AHA_SRAM_ARB_INIT_EN
    // Abort the sweep at address 100; it must restart from 0.
    @(negedge CLK);
    RESETn = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      #1;
      if (sram_a === 12'd100) found = 1'b1;
      else @(negedge CLK);
    end
    chk("sweep_reach_100", found, 1'b1);
    RESETn = 1'b0;
    #1;
    chk("abort_cen", sram_cen, 1'b1);
    chk("abort_wen", sram_wen, 8'hFF);
    chk("abort_a", sram_a, 12'h000);
    chk("abort_init_done", init_done, 1'b0);
    @(negedge CLK);
    RESETn = 1'b1;
    #1;
    chk("restart_a0", sram_a, 12'h000);
    chk("restart_cen", sram_cen, 1'b0);
    @(negedge CLK); #1;
    chk("restart_a1", sram_a, 12'h001);
`else
    @(negedge CLK);
    RESETn = 1'b1;
    #1;
    chk("post_rst_init_done", init_done, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
